// File: rtl/iram_loader.sv
// iram_loader
// Boot-time program loader for the instruction RAM. A byte stream of the form
// LEN_HI, LEN_LO, N*BYTES_W data bytes (MSB first per word), checksum is
// packed into DATA_W-bit words and written to IRAM from address 0. The core is
// held in reset until the whole image has been received and the XOR checksum
// of the data bytes matches.
//
// Ports
//   clk         single clock, all state on the rising edge
//   reset       asynchronous, active-low; clears all state while 0
//   start       one-cycle pulse; restarts a load, only honoured in DONE/ERROR
//   rx_data     stream byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte (transfer = rx_valid & rx_ready)
//   iram_addr   IRAM write address (holds its last value outside WRITE)
//   iram_data   IRAM write data    (holds its last value outside WRITE)
//   iram_wren   IRAM write strobe, one cycle per word
//   core_reset  active-high reset to the core; low only in DONE
//   done        image loaded and verified
//   error       checksum mismatch (sticky until start or reset)

module iram_loader #(
    parameter int DATA_W  = 24,
    parameter int BYTES_W = 3,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [DATA_W-1:0] iram_data,
    output logic              iram_wren,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam int CNT_W = $clog2(BYTES_W + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_W - 1);

    logic [2:0]        state_q,     state_d;
    logic [15:0]       len_q,       len_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [7:0]        csum_q,      csum_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
    logic [DATA_W-1:0] iram_data_q, iram_data_d;

    logic accept;

    // Handshake and status outputs are pure decodes of the current state.
    always_comb begin
        rx_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
        iram_wren  = (state_q == S_WRITE);
        core_reset = (state_q != S_DONE);
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERROR);
        accept     = rx_valid && rx_ready;
    end

    assign iram_addr = iram_addr_q;
    assign iram_data = iram_data_q;

    // Next-state logic. The IRAM address/data registers are loaded only on the
    // transition into WRITE, so they stay stable while the next word is being
    // shifted in and nothing downstream needs to look at them outside WRITE.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        shift_d     = shift_q;
        iram_addr_d = iram_addr_q;
        iram_data_d = iram_data_q;

        case (state_q)
            S_IDLE: state_d = S_LEN_HI;

            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    csum_d      = 8'h00;
                    addr_d      = '0;
                    cnt_d       = '0;
                    state_d     = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    // A zero-length image goes straight to the checksum byte.
                    state_d    = ({len_q[15:8], rx_data} == 16'd0) ? S_CHECK : S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
                    shift_d = {shift_q[DATA_W-9:0], rx_data};
                    csum_d  = csum_q ^ rx_data;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d       = '0;
                        iram_data_d = {shift_q[DATA_W-9:0], rx_data};
                        iram_addr_d = addr_q;
                        state_d     = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (addr_q == ADDR_W'(len_q - 16'd1)) ? S_CHECK : S_DATA;
            end

            S_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end

            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            shift_q     <= '0;
            iram_addr_q <= '0;
            iram_data_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            shift_q     <= shift_d;
            iram_addr_q <= iram_addr_d;
            iram_data_q <= iram_data_d;
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader
// Directed testbench for iram_loader. Each scenario task drives a byte stream
// and compares outputs against hand-computed values. A passive monitor logs
// every IRAM write (address/data) seen on the falling clock edge.

module tb_iram_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] iram_addr;
    logic [23:0] iram_data;
    logic        iram_wren;
    logic        core_reset;
    logic        done;
    logic        error;

    int tests;
    int fails;

    // Write log filled by the monitor.
    logic [15:0] wr_addr [0:63];
    logic [23:0] wr_data [0:63];
    int          wr_cnt;
    int          ready_in_write;

    logic [7:0]  stream [$];

    iram_loader #(.DATA_W(24), .BYTES_W(3), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .iram_addr  (iram_addr),
        .iram_data  (iram_data),
        .iram_wren  (iram_wren),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, and note any write cycle that also offers
    // rx_ready (a byte accepted there would be lost).
    always @(negedge clk) begin
        if (iram_wren === 1'b1) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = iram_addr;
                wr_data[wr_cnt] = iram_data;
            end
            wr_cnt = wr_cnt + 1;
            if (rx_ready !== 1'b0) ready_in_write = ready_in_write + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one byte (after an optional idle gap) and return on the falling
    // edge following the rising edge that transferred it. rx_valid is left high
    // so consecutive calls form a continuous-valid stream.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_byte timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input int max_gap);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({rx_ready, iram_wren, core_reset, done, error} !== 5'b00100) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b required 00100", {rx_ready, iram_wren, core_reset, done, error});
        end
        tests++;
        if (iram_addr !== 16'h0000 || iram_data !== 24'h000000) begin
            fails++;
            $display("[TB] FAIL reset_bus: got addr=%h data=%h required 0000/000000", iram_addr, iram_data);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", rx_ready);
        end
    endtask

    task automatic test_load_ok();
        int base;
        base   = wr_cnt;
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9};
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], 0);
            if (i == 4 || i == 7) begin
                // One cycle after the last byte of a word: write strobe, no ready.
                tests++;
                if ({iram_wren, rx_ready} !== 2'b10) begin
                    fails++;
                    $display("[TB] FAIL write_latency byte %0d: got wren/ready=%b required 10", i, {iram_wren, rx_ready});
                end
            end
        end
        rx_valid = 1'b0;
        tests++;
        if (wr_cnt - base !== 2) begin
            fails++;
            $display("[TB] FAIL load_ok_count: got %0d writes required 2", wr_cnt - base);
        end
        tests++;
        if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 24'h123456) begin
            fails++;
            $display("[TB] FAIL load_ok_word0: got @%h=%h required @0000=123456", wr_addr[base], wr_data[base]);
        end
        tests++;
        if (wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 24'hABCDEF) begin
            fails++;
            $display("[TB] FAIL load_ok_word1: got @%h=%h required @0001=abcdef", wr_addr[base+1], wr_data[base+1]);
        end
        tests++;
        if ({done, core_reset, error} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL load_ok_flags: got done/core_reset/error=%b required 100", {done, core_reset, error});
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        do_start();
        base   = wr_cnt;
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h00};
        send_stream(0);
        tests++;
        if (wr_cnt - base !== 2 || wr_data[base] !== 24'h123456 || wr_data[base+1] !== 24'hABCDEF) begin
            fails++;
            $display("[TB] FAIL bad_csum_writes: got %0d writes %h %h required 2 123456 abcdef",
                     wr_cnt - base, wr_data[base], wr_data[base+1]);
        end
        tests++;
        if ({done, core_reset, error} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL bad_csum_flags: got done/core_reset/error=%b required 011", {done, core_reset, error});
        end
        repeat (4) @(negedge clk);
        tests++;
        if ({error, rx_ready, core_reset} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL error_sticky: got error/ready/core_reset=%b required 101", {error, rx_ready, core_reset});
        end
    endtask

    task automatic test_zero_len();
        int base;
        do_start();
        base   = wr_cnt;
        stream = '{8'h00, 8'h00, 8'h00};
        send_stream(0);
        tests++;
        if (wr_cnt - base !== 0 || {done, core_reset, error} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL zero_len_ok: got %0d writes flags=%b required 0 writes flags=100",
                     wr_cnt - base, {done, core_reset, error});
        end
        do_start();
        base   = wr_cnt;
        stream = '{8'h00, 8'h00, 8'h5A};
        send_stream(0);
        tests++;
        if (wr_cnt - base !== 0 || {done, core_reset, error} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL zero_len_bad: got %0d writes flags=%b required 0 writes flags=011",
                     wr_cnt - base, {done, core_reset, error});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int rw;
        for (int pass = 0; pass < 2; pass++) begin
            do_start();
            base   = wr_cnt;
            rw     = ready_in_write;
            stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9};
            send_stream(pass == 0 ? 0 : 3);
            tests++;
            if (ready_in_write - rw !== 0) begin
                fails++;
                $display("[TB] FAIL b2b_ready_in_write pass %0d: got %0d cycles required 0", pass, ready_in_write - rw);
            end
            tests++;
            if (wr_cnt - base !== 2 || wr_data[base] !== 24'h123456 || wr_data[base+1] !== 24'hABCDEF ||
                wr_addr[base] !== 16'h0000 || wr_addr[base+1] !== 16'h0001) begin
                fails++;
                $display("[TB] FAIL b2b_contents pass %0d: got %0d writes @%h=%h @%h=%h required 2 @0000=123456 @0001=abcdef",
                         pass, wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
            end
            tests++;
            if ({done, core_reset, error} !== 3'b100) begin
                fails++;
                $display("[TB] FAIL b2b_flags pass %0d: got %b required 100", pass, {done, core_reset, error});
            end
        end
    endtask

    task automatic test_reset_midload();
        do_start();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB};
        send_stream(0);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({rx_ready, iram_wren, core_reset, done, error} !== 5'b00100 ||
            iram_addr !== 16'h0000 || iram_data !== 24'h000000) begin
            fails++;
            $display("[TB] FAIL async_reset: got flags=%b addr=%h data=%h required 00100 0000 000000",
                     {rx_ready, iram_wren, core_reset, done, error}, iram_addr, iram_data);
        end
        @(negedge clk);
        reset = 1'b1;
        test_load_ok();
    endtask

    task automatic test_start();
        int base;
        do_start();
        tests++;
        if ({done, core_reset, error, rx_ready} !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL start_restart: got done/core_reset/error/ready=%b required 0101",
                     {done, core_reset, error, rx_ready});
        end
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hFF, 0);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        rx_valid = 1'b0;
        tests++;
        if (wr_cnt - base !== 1 || wr_addr[base] !== 16'h0000 || wr_data[base] !== 24'hFF0000) begin
            fails++;
            $display("[TB] FAIL start_ignored_write: got %0d writes @%h=%h required 1 @0000=ff0000",
                     wr_cnt - base, wr_addr[base], wr_data[base]);
        end
        tests++;
        if ({done, core_reset, error} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL start_ignored_flags: got %b required 100", {done, core_reset, error});
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        wr_cnt         = 0;
        ready_in_write = 0;
        reset          = 1'b0;
        start          = 1'b0;
        rx_data        = 8'h00;
        rx_valid       = 1'b0;
        @(negedge clk);

        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_zero_len();
        test_back_to_back();
        test_reset_midload();
        test_start();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
